// File: rtl/lcd_pio_strobe.sv
// ----------------------------------------------------------------------------
// lcd_pio_strobe
//
// Avalon-MM output port for character-LCD buses. It provides atomic bit
// set/clear and a hardware enable-strobe sequencer. Software loads the
// data/RS/RW bits and launches E with a single CTRL write. The block then
// times setup, pulse and hold on its own.
//
// Optional feature macro: LCD_PIO_IRQ_EN
//   When defined, an irq output is added. It is a level copy of the done
//   flag. When it is undefined, there is no irq port and software polls
//   CTRL.done instead.
//
// Ports
//   clk         in   1           system clock
//   reset       in   1           synchronous, active-high reset
//   address     in   2           register select (0 DATA, 1 CTRL, 2 OUTSET, 3 OUTCLEAR)
//   chipselect  in   1           Avalon slave select
//   write_n     in   1           active-low write strobe
//   writedata   in   32          write data
//   readdata    out  32          combinational read data, zero-extended
//   out_port    out  DATA_WIDTH  LCD pins
//   busy        out  1           strobe sequence in progress
//   irq         out  1           sequence-done interrupt (LCD_PIO_IRQ_EN only)
// ----------------------------------------------------------------------------
module lcd_pio_strobe #(
    parameter int DATA_WIDTH   = 12,
    parameter int E_BIT        = 10,
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 25,
    parameter int HOLD_CYCLES  = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  busy
`ifdef LCD_PIO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

    localparam logic [DATA_WIDTH-1:0] E_MASK = DATA_WIDTH'(1) << E_BIT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    done_q;
    logic                    overrun_q;

    logic                    wr;
    logic                    idle;
    logic                    ctrl_wr;
    logic                    flag_clear;
    logic                    start_req;
    logic                    hold_end;
    logic [DATA_WIDTH-1:0]   wdata;

    assign wr         = chipselect & ~write_n;
    assign idle       = (state_q == ST_IDLE);
    assign ctrl_wr    = wr && (address == 2'd1);
    // Bit 31 of a CTRL write selects "clear flags" instead of "start".
    assign flag_clear = ctrl_wr && writedata[31];
    assign start_req  = ctrl_wr && !writedata[31];
    assign hold_end   = (state_q == ST_HOLD) && (cnt_q == '0);
    assign wdata      = writedata[DATA_WIDTH-1:0];

    // Writedata bits above the port width (other than bit 31) carry no meaning.
    generate
        if (DATA_WIDTH < 31) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^writedata[30:DATA_WIDTH];
        end
    endgenerate

    // Data register updates. Every data-changing write is blocked while a
    // strobe is running so the LCD bus stays stable around E.
    always_comb begin
        data_d = data_q;
        if (wr && idle) begin
            case (address)
                2'd0:    data_d = wdata;
                2'd1:    if (!writedata[31]) data_d = wdata & ~E_MASK;
                2'd2:    data_d = data_q | wdata;
                default: data_d = data_q & ~wdata;
            endcase
        end
    end

    // Sequencer. One down-counter is reloaded on every state change, so it
    // never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q <= data_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= SETUP_LD;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_PULSE;
                        cnt_q   <= PULSE_LD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
            // When a set and a clear land on the same edge, the set wins.
            done_q    <= hold_end | (done_q & ~flag_clear);
            overrun_q <= (start_req & ~idle) | (overrun_q & ~flag_clear);
        end
    end

    assign busy = ~idle;

    // E follows the sequencer while busy. Otherwise it is an ordinary data bit.
    always_comb begin
        out_port = data_q;
        if (!idle) out_port[E_BIT] = (state_q == ST_PULSE);
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = 32'(data_q);
            2'd1:    readdata = {29'd0, overrun_q, done_q, busy};
            default: readdata = 32'd0;
        endcase
    end

`ifdef LCD_PIO_IRQ_EN
    assign irq = done_q;
`endif

endmodule
